booth_mul_seq: RTL



---
 rtl/mul_pkg.sv | 24 ++
 rtl/booth_mul_seq_if.sv | 22 ++
 rtl/booth_recode_r4.sv | 46 ++++
 rtl/booth_mul_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier:
// FSM state encoding, Booth digit encoding and the iteration-count function.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_e;

  // Operands are widened by two bits, and each step consumes two of them.
  function automatic int booth_iters(input int width);
    return (width + 32'sd2) / 32'sd2;
  endfunction

endpackage

// File: rtl/booth_mul_seq_if.sv
// Start/done handshake and operand/result bus of the Booth multiplier.
interface booth_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, is_signed, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, is_signed, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_recode_r4.sv
// Radix-4 Booth recoder: maps the {b1, b0, cb} triple and the extended
// multiplicand Q to a sign-extended WIDTH+4-bit partial product.
module booth_recode_r4
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       trip_i,
  input  logic [WIDTH+1:0] q_i,
  output logic [WIDTH+3:0] pp_o
);

  booth_digit_e     digit_s;
  logic [WIDTH+3:0] q1_s;
  logic [WIDTH+3:0] q2_s;

  assign q1_s = {{2{q_i[WIDTH+1]}}, q_i};
  assign q2_s = {q_i[WIDTH+1], q_i, 1'b0};

  // Triple to signed digit
  always_comb begin
    digit_s = ZERO;
    case (trip_i)
      3'b000, 3'b111: digit_s = ZERO;
      3'b001, 3'b010: digit_s = POS1;
      3'b011:         digit_s = POS2;
      3'b100:         digit_s = NEG2;
      3'b101, 3'b110: digit_s = NEG1;
      default:        digit_s = ZERO;
    endcase
  end

  // Digit to partial product
  always_comb begin
    pp_o = {(WIDTH+4){1'b0}};
    case (digit_s)
      ZERO:    pp_o = {(WIDTH+4){1'b0}};
      POS1:    pp_o = q1_s;
      POS2:    pp_o = q2_s;
      NEG1:    pp_o = {(WIDTH+4){1'b0}} - q1_s;
      NEG2:    pp_o = {(WIDTH+4){1'b0}} - q2_s;
      default: pp_o = {(WIDTH+4){1'b0}};
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier, signed or unsigned, 2*WIDTH-bit product.
// Optional macro BOOTH_MUL_EARLY_TERM_EN enables early termination (variable latency).
module booth_mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  booth_mul_seq_if.slave bus
);

  localparam int N  = booth_iters(WIDTH);
  localparam int CW = $clog2(N + 1);
  localparam int EW = WIDTH + 2;
  localparam int AW = WIDTH + 4;
  localparam int PW = AW + EW;

  state_e                   state_q, state_d;
  logic [AW-1:0]            acc_q, acc_d;
  logic [EW-1:0]            mreg_q, mreg_d;
  logic [EW-1:0]            q_q, q_d;
  logic                     cb_q, cb_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [2*WIDTH-1:0]       product_q, product_d;

  logic [AW-1:0]            pp_s;
  logic [AW-1:0]            sum_s;
  logic signed [PW-1:0]     pair_s;
  logic signed [PW-1:0]     pair_step_s;

  booth_recode_r4 #(.WIDTH(WIDTH)) u_recode (
    .trip_i ({mreg_q[1:0], cb_q}),
    .q_i    (q_q),
    .pp_o   (pp_s)
  );

  assign sum_s       = acc_q + pp_s;
  assign pair_s      = {sum_s, mreg_q};
  assign pair_step_s = pair_s >>> 2'd2;

`ifdef BOOTH_MUL_EARLY_TERM_EN
  // The 2*cnt unconsumed multiplier bits plus cb all equal means every remaining digit is zero.
  logic [EW-1:0]        rem_mask_s;
  logic                 et_hit_s;
  logic signed [PW-1:0] pair_cur_s;
  logic signed [PW-1:0] pair_jump_s;

  assign rem_mask_s  = ~({EW{1'b1}} << {cnt_q, 1'b0});
  assign et_hit_s    = ((((mreg_q & rem_mask_s) == {EW{1'b0}}) && !cb_q) ||
                        (((mreg_q | ~rem_mask_s) == {EW{1'b1}}) && cb_q));
  assign pair_cur_s  = {acc_q, mreg_q};
  assign pair_jump_s = pair_cur_s >>> {cnt_q, 1'b0};
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
        else           state_d = IDLE;
      end
      RUN: begin
`ifdef BOOTH_MUL_EARLY_TERM_EN
        if (et_hit_s || (cnt_q == CW'(1))) state_d = DONE;
        else                               state_d = RUN;
`else
        if (cnt_q == CW'(1)) state_d = DONE;
        else                 state_d = RUN;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: busy follows the next state, product is captured in DONE
  always_comb begin
    busy_d    = (state_d != IDLE);
    done_d    = (state_q == DONE);
    if (state_q == DONE) begin
      product_d = {acc_q[2*WIDTH-EW-1:0], mreg_q};
    end else begin
      product_d = product_q;
    end
  end

  // Datapath next-state: operand load in IDLE, one Booth step per RUN cycle
  always_comb begin
    acc_d  = acc_q;
    mreg_d = mreg_q;
    q_d    = q_q;
    cb_d   = cb_q;
    cnt_d  = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d  = {AW{1'b0}};
          mreg_d = {{2{bus.is_signed & bus.multiplier[WIDTH-1]}}, bus.multiplier};
          q_d    = {{2{bus.is_signed & bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
          cb_d   = 1'b0;
          cnt_d  = CW'(N);
        end else begin
          cnt_d  = cnt_q;
        end
      end
      RUN: begin
`ifdef BOOTH_MUL_EARLY_TERM_EN
        if (et_hit_s) begin
          {acc_d, mreg_d} = pair_jump_s;
          cb_d            = cb_q;
          cnt_d           = {CW{1'b0}};
        end else begin
          {acc_d, mreg_d} = pair_step_s;
          cb_d            = mreg_q[1];
          cnt_d           = cnt_q - CW'(1);
        end
`else
        {acc_d, mreg_d} = pair_step_s;
        cb_d            = mreg_q[1];
        cnt_d           = cnt_q - CW'(1);
`endif
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= {AW{1'b0}};
      mreg_q    <= {EW{1'b0}};
      q_q       <= {EW{1'b0}};
      cb_q      <= 1'b0;
      cnt_q     <= {CW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= {(2*WIDTH){1'b0}};
    end else begin
      acc_q     <= acc_d;
      mreg_q    <= mreg_d;
      q_q       <= q_d;
      cb_q      <= cb_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule
